// File: rtl/spi_master_if.sv
// Bus between the CPU-side register block and the SPI master, plus the SPI pins.
// The master modport is the SPI master's view; slave is the register block / bus side.
interface spi_master_if #(
    parameter int NUM_CS   = 4,
    parameter int CS_WIDTH = 2
);
    logic                tx_valid;
    logic                tx_ready;
    logic [7:0]          tx_data;
    logic [CS_WIDTH-1:0] cs_sel;
    logic                cs_hold;
    logic                cs_release;
    logic [7:0]          divider;
    logic                rx_valid;
    logic [7:0]          rx_data;
    logic                busy;
    logic                sclk;
    logic [NUM_CS-1:0]   ncs;
    logic                mosi;
    logic                miso;

    modport master (
        input  tx_valid, tx_data, cs_sel, cs_hold, cs_release, divider, miso,
        output tx_ready, rx_valid, rx_data, busy, sclk, ncs, mosi
    );

    modport slave (
        output tx_valid, tx_data, cs_sel, cs_hold, cs_release, divider, miso,
        input  tx_ready, rx_valid, rx_data, busy, sclk, ncs, mosi
    );
endinterface

// File: rtl/spi_master.sv
// Byte-oriented SPI master, mode 0, MSB first, with programmable sclk half-period
// and per-device active-low chip selects that can be held across bytes.
module spi_master #(
    parameter int NUM_CS   = 4,
    parameter int CS_WIDTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, HOLD, RELEASE} state_e;

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [7:0]          div_q, div_d;
    logic [7:0]          tx_q, tx_d;
    logic [7:0]          rx_sh_q, rx_sh_d;
    logic [7:0]          rx_data_q, rx_data_d;
    logic [2:0]          bit_q, bit_d;
    logic [CS_WIDTH-1:0] sel_q, sel_d;
    logic                hold_q, hold_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                rx_valid_q, rx_valid_d;
    logic [NUM_CS-1:0]   ncs_q, ncs_d;
    logic [NUM_CS-1:0]   ncs_dec;
    logic                tx_ready;
    logic                start;

    // Selects at or above NUM_CS match no bit, so the byte is clocked with all ncs high.
    always_comb begin
        for (int i = 0; i < NUM_CS; i++) begin
            ncs_dec[i] = (int'(bus.cs_sel) != i);
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        tx_d       = tx_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        bit_d      = bit_q;
        sel_d      = sel_q;
        hold_d     = hold_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ncs_d      = ncs_q;
        rx_valid_d = 1'b0;
        tx_ready   = 1'b0;
        start      = 1'b0;

        case (state_q)
            IDLE: begin
                tx_ready = 1'b1;
                start    = bus.tx_valid;
            end
            SHIFT_LO: begin
                if (cnt_q == 8'd0) begin
                    cnt_d   = div_q;
                    sclk_d  = 1'b1;
                    rx_sh_d = {rx_sh_q[6:0], bus.miso};
                    state_d = SHIFT_HI;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SHIFT_HI: begin
                if (cnt_q == 8'd0) begin
                    cnt_d  = div_q;
                    sclk_d = 1'b0;
                    if (bit_q == 3'd7) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_sh_q;
                        bit_d      = 3'd0;
                        state_d    = hold_q ? HOLD : RELEASE;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = tx_q << 1;
                        mosi_d  = tx_q[6];
                        state_d = SHIFT_LO;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            HOLD: begin
                // A request for another device is refused; it is taken again from IDLE.
                tx_ready = !bus.cs_release && (!bus.tx_valid || bus.cs_sel == sel_q);
                if (bus.cs_release || (bus.tx_valid && bus.cs_sel != sel_q)) begin
                    cnt_d   = div_q;
                    state_d = RELEASE;
                end else begin
                    start = bus.tx_valid;
                end
            end
            RELEASE: begin
                if (cnt_q == 8'd0) begin
                    ncs_d   = '1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            tx_d    = bus.tx_data;
            mosi_d  = bus.tx_data[7];
            sel_d   = bus.cs_sel;
            hold_d  = bus.cs_hold;
            div_d   = bus.divider;
            cnt_d   = bus.divider;
            bit_d   = 3'd0;
            sclk_d  = 1'b0;
            ncs_d   = ncs_dec;
            state_d = SHIFT_LO;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            div_q      <= 8'd0;
            tx_q       <= 8'd0;
            rx_sh_q    <= 8'd0;
            rx_data_q  <= 8'd0;
            bit_q      <= 3'd0;
            sel_q      <= '0;
            hold_q     <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            ncs_q      <= '1;
        end else begin
            // NOTE: non-blocking so every register updates from the values present before the edge.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            tx_q       <= tx_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            bit_q      <= bit_d;
            sel_q      <= sel_d;
            hold_q     <= hold_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            rx_valid_q <= rx_valid_d;
            ncs_q      <= ncs_d;
        end
    end

    assign bus.tx_ready = tx_ready;
    assign bus.busy     = (state_q != IDLE);
    assign bus.sclk     = sclk_q;
    assign bus.mosi     = mosi_q;
    assign bus.ncs      = ncs_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Byte-oriented SPI master (mode 0, MSB first) that drives the SPI slave models and SPI peripherals on the external bus.
- Takes bytes from the CPU-side peripheral register block over a valid/ready handshake and serialises them onto mosi.
- Shifts in the returned miso byte and presents it as a one-cycle rx_valid pulse.
- Generates sclk from a programmable divider and per-device active-low chip selects, with optional chip-select hold across bytes.

Parameters:
- NUM_CS, 4, number of chip-select outputs.
- CS_WIDTH, 2, width of cs_sel; must satisfy 2^CS_WIDTH >= NUM_CS.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- tx_valid  input  1  transfer request.
- tx_ready  output  1  master can accept a request this cycle.
- tx_data  input  8  byte to send.
- cs_sel  input  CS_WIDTH  target device index.
- cs_hold  input  1  keep ncs asserted after this byte.
- cs_release  input  1  one-cycle pulse that ends a held chip select.
- divider  input  8  half-period of sclk is divider+1 clk cycles.
- rx_valid  output  1  one-cycle pulse: rx_data valid.
- rx_data  output  8  last received byte.
- busy  output  1  high in any state other than IDLE.
- sclk  output  1  SPI clock; idles low.
- ncs  output  NUM_CS  active-low chip selects.
- mosi  output  1  serial data to slave.
- miso  input  1  serial data from slave.

Behaviour:
- Reset (async):
  - State IDLE.
  - sclk=0, ncs all 1s, mosi=0, rx_valid=0, rx_data=0x00, busy=0.
  - Reset mid-transfer aborts immediately; no rx_valid is produced.
- Latched at accept: an accept is a cycle with tx_valid & tx_ready.
  - The master latches tx_data, cs_sel, cs_hold and divider (H = divider+1).
  - Changes to these inputs during a transfer are ignored.
- States: IDLE, SHIFT_LO, SHIFT_HI, HOLD, RELEASE.
- tx_ready:
  - IDLE: 1.
  - HOLD: 1 only when cs_release=0 and (tx_valid=0 or cs_sel equals the held select).
  - All other states: 0.
- Accept at cycle T (from IDLE or HOLD):
  - At T+1: ncs[sel] low (other ncs bits high), mosi = tx_data[7], sclk=0, state SHIFT_LO, half-period counter loaded.
- SHIFT_LO -> SHIFT_HI after H cycles.
  - On the clk edge that drives sclk high, miso (the value held during the low phase) is shifted into the rx shift register LSB.
- SHIFT_HI -> SHIFT_LO after H cycles.
  - sclk is driven low and mosi advances to the next bit on the same edge.
  - A 3-bit bit counter increments.
- After the 8th sclk high phase, sclk goes low at cycle T+1+16H.
  - In that same cycle rx_valid=1 and rx_data = received byte (first bit = bit 7).
  - rx_data holds until the next completion.
  - Next state is HOLD if cs_hold was latched high, else RELEASE.
- HOLD:
  - ncs stays asserted; sclk=0; mosi holds the last bit.
  - An accept with the same cs_sel starts the next byte exactly as above; no ncs gap.
  - cs_release=1 -> RELEASE. cs_release wins over a simultaneous tx_valid.
  - tx_valid with a different cs_sel -> RELEASE (not accepted); the request is accepted later from IDLE.
- RELEASE:
  - ncs stays low for H cycles, then all ncs go high and the state returns to IDLE.
  - Entered straight after the last byte, ncs rises at T+1+17H.
  - Minimum ncs-high time between devices is 1 cycle.
- cs_sel >= NUM_CS: the transfer is clocked normally but no ncs bit asserts.
- cs_release in IDLE or during shifting is ignored.
- divider=0 (H=1): sclk = clk/2; all timing above still holds.
- busy = (state != IDLE).

Test Plan:
- Reset then idle -> sclk=0, ncs=4'b1111, tx_ready=1, busy=0, rx_valid never asserts.
- Single byte: divider=1, cs_sel=2, tx_data=0xA5, cs_hold=0, slave returns 0x3C.
  - mosi bits 1,0,1,0,0,1,0,1; 8 sclk pulses, each 2 cycles high / 2 cycles low.
  - ncs=4'b1011 from T+1 to T+34.
  - rx_valid single pulse at T+33 with rx_data=0x3C.
- Held burst: 0x01 then 0x02 to cs 0, cs_hold=1 on both, then cs_release.
  - ncs[0] never deasserts between bytes.
  - Two rx_valid pulses.
  - ncs[0] rises H cycles after cs_release.
- Device switch: hold on cs 1, then tx_valid with cs_sel=3.
  - tx_ready=0, RELEASE, ncs all high for at least 1 cycle.
  - The request is accepted from IDLE and ncs=4'b0111.
- Reset mid-byte: assert rst after 3 sclk pulses.
  - Outputs return to reset values immediately; no rx_valid.
  - The next transfer after reset completes correctly.
- Divider/input change mid-transfer: divider 0 -> 7 and tx_data changed during the byte.
  - The current byte keeps H=1 and the original data.
  - The next byte uses H=8.
